instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//  Fetch front end feeding MIPS_core: issues word-addressed requests to
//  instruction memory, buffers returned words in an in-order prefetch FIFO and
//  presents {instruction, pc} to the core over a valid/ready handshake.
//  Core-resolved jumps/branches arrive as a redirect that flushes the FIFO and
//  discards responses still in flight.
// PARAMETERS
//  DEPTH    4   FIFO entries; also caps FIFO occupancy + outstanding requests (power of 2, >=2)
//  RESET_PC 0   first fetch address after reset (word address)
// PORTS
//  clock          in   1   all state updates on posedge
//  reset_n        in   1   asynchronous, active-low reset
//  imem_req_valid out  1   fetch request valid
//  imem_req_ready in   1   memory accepts request this cycle
//  imem_req_addr  out  32  word address of request
//  imem_rsp_valid in   1   response word valid (in request order, >=1 cycle after accept)
//  imem_rsp_data  in   32  instruction word
//  ins_valid      out  1   FIFO head valid to core
//  ins_ready      in   1   core consumes head this cycle
//  ins_data       out  32  head instruction
//  ins_pc         out  32  word address of head instruction
//  redirect_valid in   1   core takes jump/jr/branch
//  redirect_pc    in   32  new fetch word address
//  busy_drain     out  1   high while in DRAIN
// BEHAVIOUR
//  Reset (reset_n=0, async): state IDLE; fetch_pc=RESET_PC; FIFO count=0;
//   outstanding=0; imem_req_valid=0; ins_valid=0; ins_data=0; ins_pc=0; busy_drain=0.
//  States: IDLE -> FETCH on first clock after reset release.
//   FETCH: imem_req_valid=1 iff count+outstanding < DEPTH and !redirect_valid;
//    imem_req_addr=fetch_pc; request accepted (valid&ready) -> fetch_pc+=1
//    (mod 2^32, wraps 0xFFFFFFFF->0), outstanding+=1, pc tagged into pc queue.
//   Redirect in FETCH: FIFO flushed (count=0), fetch_pc=redirect_pc; if
//    outstanding after this cycle's accept/response >0 -> DRAIN, else stay FETCH.
//   DRAIN: imem_req_valid=0; every response dropped, outstanding-=1; at
//    outstanding==0 -> FETCH next cycle. Redirect in DRAIN: fetch_pc=redirect_pc, stay.
//  FIFO: response in FETCH (no redirect) pushed at tail with its tagged pc;
//   visible on ins_* the following cycle (1-cycle rsp->ins latency).
//   Pop on ins_valid&ins_ready; push and pop same cycle legal at any count.
//   Overflow impossible by credit rule; a response with count==DEPTH is an
//   assertion failure.
//  ins_valid = count>0 and no redirect was taken in the previous cycle;
//   ins_data/ins_pc hold stable while ins_valid&!ins_ready.
//  Simultaneous events:
//   redirect + pop: pop counts as delivered, then flush.
//   redirect + response: response dropped (stale), outstanding-=1.
//   redirect + request accept: that request counted stale (dropped later).
//   redirect blocks new request in the same cycle.
//  Reset mid-operation: all state cleared immediately; responses arriving
//   after reset release for pre-reset requests are the memory's responsibility
//   (memory reset on same reset_n).
//  Throughput: with ready memory (1-cycle rsp) and ins_ready=1: one ins/cycle.
// TESTING
//  1 Reset, imem always ready, 1-cycle rsp, ins_ready=1 -> ins_pc 0,1,2,3...
//    one per cycle from cycle 3, ins_data matches mem[pc].
//  2 ins_ready=0 for 10 cycles -> exactly DEPTH=4 requests issued, then
//    imem_req_valid=0; head stays pc 0; release -> pcs 0..N in order, no loss.
//  3 Rsp latency 3, redirect_pc=0x40 with 3 outstanding -> busy_drain=1,
//    3 responses dropped, next ins_pc=0x40, no stale instruction delivered.
//  4 Redirect same cycle as response and pop -> popped ins counted once,
//    response dropped, next ins_pc=redirect_pc.
//  5 redirect_pc=0xFFFFFFFE -> ins_pc 0xFFFFFFFE, 0xFFFFFFFF, 0x0 (wrap).
//  6 reset_n low mid-DRAIN with 2 outstanding -> outputs zero async;
//    after release fetch restarts at RESET_PC, busy_drain=0.

Source files
------------

// File: rtl/instr_fetch_queue_if.sv
// rtl/instr_fetch_queue_if.sv - fetch front end memory, core and redirect signal bundle
interface instr_fetch_queue_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy_drain;

  modport master (
    output imem_req_valid, imem_req_addr, ins_valid, ins_data, ins_pc, busy_drain,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, ins_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, ins_valid, ins_data, ins_pc, busy_drain,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, ins_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction fetch front end with in-order prefetch FIFO and redirect drain
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                clock,
  input  logic                reset_n,
  instr_fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_X = (CW+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic          redir_prev_q;

  logic [31:0] fifo_data_q [DEPTH];
  logic [31:0] fifo_pc_q   [DEPTH];
  logic [31:0] tag_pc_q    [DEPTH];

  logic redirect, credit_ok, req_valid, accept, rsp, push, pop, ins_valid;

  // Credits cover both buffered words and words still in flight, so a response always has a slot.
  assign redirect  = bus.redirect_valid;
  assign credit_ok = ({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_X;
  assign req_valid = (state_q == ST_FETCH) && credit_ok && !redirect;
  assign accept    = req_valid && bus.imem_req_ready;
  assign rsp       = bus.imem_rsp_valid && (outst_q != '0);
  assign push      = rsp && (state_q == ST_FETCH) && !redirect;
  assign ins_valid = (count_q != '0) && !redir_prev_q;
  assign pop       = ins_valid && bus.ins_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;
    outst_d    = outst_q + CW'(accept) - CW'(rsp);
    count_d    = count_q + CW'(push) - CW'(pop);

    if (push)   tail_d   = tail_q + AW'(1);
    if (pop)    head_d   = head_q + AW'(1);
    if (accept) tag_wr_d = tag_wr_q + AW'(1);
    if (rsp)    tag_rd_d = tag_rd_q + AW'(1);
    if (accept) fetch_pc_d = fetch_pc_q + 32'd1;

    // A same-cycle pop has already been delivered; everything left is flushed.
    if (redirect) begin
      fetch_pc_d = bus.redirect_pc;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
    end

    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (redirect && (outst_d != '0)) state_d = ST_DRAIN;
      ST_DRAIN: if (outst_d == '0) state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      fetch_pc_q   <= RESET_PC;
      count_q      <= '0;
      outst_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      tag_rd_q     <= '0;
      tag_wr_q     <= '0;
      redir_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      count_q      <= count_d;
      outst_q      <= outst_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      tag_rd_q     <= tag_rd_d;
      tag_wr_q     <= tag_wr_d;
      redir_prev_q <= redirect;
    end
  end

  // Storage needs no reset: the head is only exposed while count is non-zero.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data_q[tail_q] <= bus.imem_rsp_data;
      fifo_pc_q[tail_q]   <= tag_pc_q[tag_rd_q];
    end
    if (accept) tag_pc_q[tag_wr_q] <= fetch_pc_q;
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.ins_valid      = ins_valid;
  assign bus.ins_data       = ins_valid ? fifo_data_q[head_q] : 32'd0;
  assign bus.ins_pc         = ins_valid ? fifo_pc_q[head_q] : 32'd0;
  assign bus.busy_drain     = (state_q == ST_DRAIN);

  assert property (@(posedge clock) disable iff (!reset_n)
    !(bus.imem_rsp_valid && (count_q == DEPTH_C)));
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'd0;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  instr_fetch_queue_if bus();

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rel0     = 0;
  int mem_lat  = 1;
  int mem_rdy  = 100;
  int n_accept = 0;
  int n_rsp    = 0;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] dq_pc[$];
  logic [31:0] dq_data[$];
  int          dq_cyc[$];
  logic [31:0] rd_pc[$];
  int          rd_cyc[$];
  logic [31:0] exp_pc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // Expected delivery stream: sequential pcs, restarted at each redirect taken before the delivery cycle.
  function automatic void build_expected();
    logic [31:0] nxt;
    int r;
    nxt = RST_PC;
    r = 0;
    exp_pc.delete();
    foreach (dq_cyc[i]) begin
      while (r < rd_cyc.size() && rd_cyc[r] < dq_cyc[i]) begin
        nxt = rd_pc[r];
        r++;
      end
      exp_pc.push_back(nxt);
      nxt = nxt + 32'd1;
    end
  endfunction

  // Instruction memory: in-order responses, fixed latency, optional random request stall.
  always @(posedge clock) begin
    cyc = cyc + 1;
    #1;
    if (!reset_n) begin
      mq_addr.delete();
      mq_due.delete();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'd0;
      bus.imem_req_ready = 1'b0;
    end else begin
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(mq_addr[0]);
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = $urandom;
      end
      bus.imem_req_ready = ($urandom_range(99) < mem_rdy);
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        mq_addr.push_back(bus.imem_req_addr);
        mq_due.push_back(cyc + mem_lat);
        n_accept++;
      end
      if (bus.imem_rsp_valid) n_rsp++;
      if (bus.ins_valid && bus.ins_ready) begin
        dq_pc.push_back(bus.ins_pc);
        dq_data.push_back(bus.ins_data);
        dq_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic set_redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    rd_pc.push_back(pc);
    rd_cyc.push_back(cyc);
  endtask

  task automatic do_reset(input int lat, input int rdy);
    reset_n            = 1'b0;
    bus.ins_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    mem_lat            = lat;
    mem_rdy            = rdy;
    tick(2);
    reset_n = 1'b1;
    rel0    = cyc;
    dq_pc.delete(); dq_data.delete(); dq_cyc.delete();
    rd_pc.delete(); rd_cyc.delete();
    n_accept = 0;
    n_rsp    = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clock);
    checks++;
    if ({bus.imem_req_valid, bus.ins_valid, bus.busy_drain} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {bus.imem_req_valid, bus.ins_valid, bus.busy_drain});
    end
    checks++;
    if ({bus.ins_data, bus.ins_pc} !== 64'd0) begin
      failures++; $display("FAIL reset_ins got=%h/%h exp=0/0", bus.ins_data, bus.ins_pc);
    end
    do_reset(1, 100);
    @(negedge clock);
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL idle_req got=%b exp=0", bus.imem_req_valid);
    end
    @(negedge clock);
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RST_PC) begin
      failures++; $display("FAIL first_req got=%b@%h exp=1@%h", bus.imem_req_valid, bus.imem_req_addr, RST_PC);
    end
  endtask

  task automatic test_stream();
    do_reset(1, 100);
    bus.ins_ready = 1'b1;
    tick(12);
    checks++;
    if (dq_pc.size() != 9) begin
      failures++; $display("FAIL stream_count got=%0d exp=9", dq_pc.size());
    end
    foreach (dq_pc[i]) begin
      checks++;
      if (dq_pc[i] !== 32'(i) || dq_data[i] !== mem_word(32'(i)) || dq_cyc[i] != rel0 + 3 + i) begin
        failures++;
        $display("FAIL stream[%0d] got pc=%h data=%h cyc=%0d exp pc=%h data=%h cyc=%0d",
                 i, dq_pc[i], dq_data[i], dq_cyc[i] - rel0, 32'(i), mem_word(32'(i)), 3 + i);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1, 100);
    tick(5);
    @(negedge clock);
    checks++;
    if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'd0) begin
      failures++; $display("FAIL stall_head_early got=%b/%h exp=1/0", bus.ins_valid, bus.ins_pc);
    end
    tick(5);
    checks++;
    if (n_accept != DEPTH) begin
      failures++; $display("FAIL stall_requests got=%0d exp=%0d", n_accept, DEPTH);
    end
    @(negedge clock);
    checks++;
    if (bus.imem_req_valid !== 1'b0 || bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'd0
        || bus.ins_data !== mem_word(32'd0)) begin
      failures++;
      $display("FAIL stall_head got req=%b valid=%b pc=%h data=%h exp 0/1/0/%h",
               bus.imem_req_valid, bus.ins_valid, bus.ins_pc, bus.ins_data, mem_word(32'd0));
    end
    tick(1);
    bus.ins_ready = 1'b1;
    tick(15);
    checks++;
    if (dq_pc.size() < 12) begin
      failures++; $display("FAIL release_count got=%0d exp>=12", dq_pc.size());
    end
    foreach (dq_pc[i]) begin
      checks++;
      if (dq_pc[i] !== 32'(i) || dq_data[i] !== mem_word(32'(i))) begin
        failures++; $display("FAIL release[%0d] got pc=%h exp=%h", i, dq_pc[i], 32'(i));
      end
    end
  endtask

  task automatic test_drain();
    int r;
    bit seen_idle;
    do_reset(3, 100);
    bus.ins_ready = 1'b1;
    tick(4);
    checks++;
    if (n_accept != 3) begin
      failures++; $display("FAIL drain_outstanding got=%0d exp=3", n_accept);
    end
    r = n_rsp;
    set_redirect(32'h40);
    tick(1);
    bus.redirect_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.busy_drain !== 1'b1) begin
      failures++; $display("FAIL drain_busy got=%b exp=1", bus.busy_drain);
    end
    seen_idle = 1'b0;
    for (int k = 0; k < 20 && !seen_idle; k++) begin
      @(negedge clock);
      if (bus.busy_drain === 1'b0) seen_idle = 1'b1;
    end
    #1;
    checks++;
    if (!seen_idle) begin
      failures++; $display("FAIL drain_timeout got=busy exp=idle within 20 cycles");
    end
    checks++;
    if (n_rsp - r != 3) begin
      failures++; $display("FAIL drain_dropped got=%0d exp=3", n_rsp - r);
    end
    tick(10);
    checks++;
    if (dq_pc.size() < 4) begin
      failures++; $display("FAIL drain_after_count got=%0d exp>=4", dq_pc.size());
    end
    foreach (dq_pc[i]) begin
      checks++;
      if (dq_pc[i] !== 32'h40 + 32'(i) || dq_data[i] !== mem_word(32'h40 + 32'(i))) begin
        failures++; $display("FAIL drain_after[%0d] got pc=%h exp=%h", i, dq_pc[i], 32'h40 + 32'(i));
      end
    end
  endtask

  task automatic test_redirect_collide();
    int n5;
    int n6;
    do_reset(1, 100);
    bus.ins_ready = 1'b1;
    tick(8);
    set_redirect(32'h200);
    @(negedge clock);
    checks++;
    if (bus.imem_rsp_valid !== 1'b1 || bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'd5) begin
      failures++;
      $display("FAIL collide_setup got rsp=%b valid=%b pc=%h exp 1/1/5", bus.imem_rsp_valid, bus.ins_valid, bus.ins_pc);
    end
    @(posedge clock);
    #2;
    bus.redirect_valid = 1'b0;
    tick(8);
    build_expected();
    n5 = 0;
    n6 = 0;
    foreach (dq_pc[i]) begin
      if (dq_pc[i] == 32'd5) n5++;
      if (dq_pc[i] == 32'd6) n6++;
      checks++;
      if (dq_pc[i] !== exp_pc[i] || dq_data[i] !== mem_word(exp_pc[i])) begin
        failures++; $display("FAIL collide[%0d] got pc=%h exp=%h", i, dq_pc[i], exp_pc[i]);
      end
    end
    checks++;
    if (n5 != 1 || n6 != 0) begin
      failures++; $display("FAIL collide_once got n5=%0d n6=%0d exp n5=1 n6=0", n5, n6);
    end
    checks++;
    if (dq_pc.size() < 7 || dq_pc[6] !== 32'h200) begin
      failures++; $display("FAIL collide_next got count=%0d exp pc 0x200 at index 6", dq_pc.size());
    end
  endtask

  task automatic test_wrap();
    do_reset(1, 100);
    bus.ins_ready = 1'b1;
    tick(2);
    set_redirect(32'hFFFF_FFFE);
    tick(1);
    bus.redirect_valid = 1'b0;
    tick(10);
    build_expected();
    checks++;
    if (dq_pc.size() < 4) begin
      failures++; $display("FAIL wrap_count got=%0d exp>=4", dq_pc.size());
    end else begin
      checks++;
      if (dq_pc[0] !== 32'hFFFF_FFFE || dq_pc[1] !== 32'hFFFF_FFFF || dq_pc[2] !== 32'd0) begin
        failures++; $display("FAIL wrap_seq got %h %h %h exp fffffffe ffffffff 0", dq_pc[0], dq_pc[1], dq_pc[2]);
      end
    end
    foreach (dq_pc[i]) begin
      checks++;
      if (dq_pc[i] !== exp_pc[i] || dq_data[i] !== mem_word(exp_pc[i])) begin
        failures++; $display("FAIL wrap[%0d] got pc=%h exp=%h", i, dq_pc[i], exp_pc[i]);
      end
    end
  endtask

  task automatic test_reset_in_drain();
    do_reset(3, 100);
    bus.ins_ready = 1'b1;
    tick(4);
    set_redirect(32'h80);
    tick(1);
    bus.redirect_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.busy_drain !== 1'b1) begin
      failures++; $display("FAIL rstdrain_setup got=%b exp=1", bus.busy_drain);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy_drain, bus.imem_req_valid, bus.ins_valid} !== 3'b000
        || {bus.ins_data, bus.ins_pc} !== 64'd0) begin
      failures++;
      $display("FAIL rstdrain_async got drain=%b req=%b valid=%b data=%h pc=%h exp all zero",
               bus.busy_drain, bus.imem_req_valid, bus.ins_valid, bus.ins_data, bus.ins_pc);
    end
    do_reset(1, 100);
    bus.ins_ready = 1'b1;
    tick(10);
    @(negedge clock);
    checks++;
    if (bus.busy_drain !== 1'b0) begin
      failures++; $display("FAIL rstdrain_busy got=%b exp=0", bus.busy_drain);
    end
    checks++;
    if (dq_pc.size() < 7 || dq_cyc[0] != rel0 + 3) begin
      failures++; $display("FAIL rstdrain_restart got count=%0d exp>=7 starting at cycle 3", dq_pc.size());
    end
    foreach (dq_pc[i]) begin
      checks++;
      if (dq_pc[i] !== RST_PC + 32'(i) || dq_data[i] !== mem_word(RST_PC + 32'(i))) begin
        failures++; $display("FAIL rstdrain[%0d] got pc=%h exp=%h", i, dq_pc[i], RST_PC + 32'(i));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rp;
    int last_rd;
    int tail_n;
    for (int it = 0; it < 4; it++) begin
      do_reset(int'($urandom_range(3, 1)), int'($urandom_range(100, 40)));
      for (int c = 0; c < 200; c++) begin
        bus.ins_ready = ($urandom_range(99) < 70);
        if (c >= 2 && $urandom_range(99) < 4) begin
          rp = $urandom;
          if ($urandom_range(1) == 1) rp[31:3] = '1;
          set_redirect(rp);
        end else begin
          bus.redirect_valid = 1'b0;
        end
        tick(1);
      end
      bus.redirect_valid = 1'b0;
      bus.ins_ready      = 1'b1;
      mem_rdy            = 100;
      tick(40);
      build_expected();
      foreach (dq_pc[i]) begin
        checks++;
        if (dq_pc[i] !== exp_pc[i] || dq_data[i] !== mem_word(exp_pc[i])) begin
          failures++;
          $display("FAIL random%0d[%0d] got pc=%h data=%h exp pc=%h data=%h",
                   it, i, dq_pc[i], dq_data[i], exp_pc[i], mem_word(exp_pc[i]));
        end
      end
      last_rd = (rd_cyc.size() > 0) ? rd_cyc[rd_cyc.size() - 1] : rel0;
      tail_n = 0;
      foreach (dq_cyc[i]) if (dq_cyc[i] > last_rd) tail_n++;
      checks++;
      if (tail_n < 15) begin
        failures++; $display("FAIL random%0d_progress got=%0d exp>=15", it, tail_n);
      end
    end
  endtask

  initial begin
    bus.ins_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    test_reset();
    test_stream();
    test_backpressure();
    test_drain();
    test_redirect_collide();
    test_wrap();
    test_reset_in_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
